// File: rtl/bist_pkg.sv
// Shared types and helpers for the scan BIST sequencer: FSM state encoding,
// maximal-length tap masks per width and the common LFSR step.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_COMPARE,
        ST_DONE
    } bist_state_t;

    // Tap masks (bit i set = q[i] tapped) from the Xilinx maximal-length tables.
    function automatic logic [31:0] default_poly(input int width);
        case (width)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Shift left, new LSB is the parity of the tapped bits; result masked to width.
    function automatic logic [31:0] lfsr_step(input logic [31:0] q,
                                              input logic [31:0] poly,
                                              input int width);
        logic [31:0] mask;
        logic        fb;
        mask = (32'd1 << width) - 32'd1;
        fb   = ^(q & poly & mask);
        return ((q << 1) | {31'd0, fb}) & mask;
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Fibonacci-style LFSR shared by the pattern generator and the signature
// compactor; with compact=1 the parallel input d is folded into every step.
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             CK,
    input  logic             reset_n,
    input  logic             load,
    input  logic             en,
    input  logic             compact,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge CK or negedge reset_n) begin
        if (!reset_n) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (en) begin
            q <= WIDTH'(lfsr_step(32'(q), 32'(POLY), WIDTH)) ^ (compact ? d : '0);
        end
    end

endmodule

// File: rtl/bist_ctrl.sv
// Multi-chain scan BIST sequencer: drives scan_en through shift/capture for a
// fixed pattern count, compacts scan-outs in a MISR and checks the signature.
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int                  N_CHAINS   = 7,
    parameter int                  CHAIN_LEN  = 32,
    parameter int                  N_PATTERNS = 256,
    parameter logic [N_CHAINS-1:0] TPG_POLY   = N_CHAINS'(default_poly(N_CHAINS)),
    parameter logic [N_CHAINS-1:0] MISR_POLY  = N_CHAINS'(default_poly(N_CHAINS)),
    parameter logic [N_CHAINS-1:0] TPG_SEED   = N_CHAINS'(1),
    parameter logic [N_CHAINS-1:0] GOLDEN_SIG = '0,
    localparam int                 PCW        = $clog2(N_PATTERNS + 1),
    localparam int                 SCW        = $clog2(CHAIN_LEN + 1)
) (
    input  logic                CK,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [N_CHAINS-1:0] so,
    output logic [N_CHAINS-1:0] si,
    output logic                scan_en,
    output logic                bist_en,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_CHAINS-1:0] signature,
    output logic [PCW-1:0]      pattern_cnt,
    output bist_state_t         state
);

    localparam logic [SCW-1:0] SHIFT_LAST = SCW'(CHAIN_LEN - 1);
    localparam logic [PCW-1:0] PAT_LAST   = PCW'(N_PATTERNS - 1);

    logic [SCW-1:0] shift_cnt;
    logic           shift_last;
    logic           start_ok;
    logic           tpg_en;
    logic           misr_en;

    assign shift_last = (shift_cnt == SHIFT_LAST);
    assign start_ok   = start && !abort && (state == ST_IDLE || state == ST_DONE);
    assign tpg_en     = !abort && (state == ST_SHIFT);
    // The first load's unload carries uninitialised flop contents, so skip it.
    assign misr_en    = !abort && ((state == ST_SHIFT && pattern_cnt != '0) ||
                                   state == ST_UNLOAD);

    bist_lfsr #(
        .WIDTH (N_CHAINS),
        .POLY  (TPG_POLY),
        .SEED  (TPG_SEED)
    ) u_tpg (
        .CK      (CK),
        .reset_n (reset_n),
        .load    (start_ok),
        .en      (tpg_en),
        .compact (1'b0),
        .d       ('0),
        .q       (si)
    );

    bist_lfsr #(
        .WIDTH (N_CHAINS),
        .POLY  (MISR_POLY),
        .SEED  ('0)
    ) u_misr (
        .CK      (CK),
        .reset_n (reset_n),
        .load    (start_ok),
        .en      (misr_en),
        .compact (1'b1),
        .d       (so),
        .q       (signature)
    );

    always_ff @(posedge CK or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            shift_cnt   <= '0;
            pattern_cnt <= '0;
            scan_en     <= 1'b0;
            bist_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else if (abort) begin
            state     <= ST_IDLE;
            shift_cnt <= '0;
            scan_en   <= 1'b0;
            bist_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_SHIFT;
                        shift_cnt   <= '0;
                        pattern_cnt <= '0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        scan_en     <= 1'b1;
                        bist_en     <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (shift_last) begin
                        shift_cnt <= '0;
                        scan_en   <= 1'b0;
                        state     <= ST_CAPTURE;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    pattern_cnt <= pattern_cnt + 1'b1;
                    scan_en     <= 1'b1;
                    state       <= (pattern_cnt == PAT_LAST) ? ST_UNLOAD : ST_SHIFT;
                end
                ST_UNLOAD: begin
                    if (shift_last) begin
                        shift_cnt <= '0;
                        scan_en   <= 1'b0;
                        state     <= ST_COMPARE;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    pass    <= (signature == GOLDEN_SIG);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    bist_en <= 1'b0;
                    state   <= ST_DONE;
                end
                default: begin
                    state   <= ST_IDLE;
                    scan_en <= 1'b0;
                    bist_en <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_ctrl.sv
// Bench for bist_ctrl: cycle-count based reference model checked every cycle,
// plus directed runs with hand-computed timing, sequence and signature values.
module tb_bist_ctrl;
    import bist_pkg::*;

    localparam int L      = 4;
    localparam int NP     = 2;
    localparam int RUN_SC = NP * (L + 1);
    localparam logic [6:0] POLY = 7'h60;

    logic        clk;
    logic        rst_n;
    logic        start, abort;
    logic [6:0]  so;
    logic [6:0]  si, signature;
    logic        scan_en, bist_en, busy, done, pass;
    logic [1:0]  pattern_cnt;
    bist_state_t state_s;

    logic        start_l, abort_l;
    logic [6:0]  so_l;
    logic [6:0]  si_l, signature_l;
    logic        scan_en_l, bist_en_l, busy_l, done_l, pass_l;
    logic [0:0]  pattern_cnt_l;
    bist_state_t state_l;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    logic        m_run, m_done, m_pass;
    int          m_k, m_pcnt;
    logic [6:0]  m_tpg, m_misr;
    logic [6:0]  lit [7] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41};

    bist_ctrl #(.CHAIN_LEN(L), .N_PATTERNS(NP)) dut (
        .CK(clk), .reset_n(rst_n), .start(start), .abort(abort), .so(so),
        .si(si), .scan_en(scan_en), .bist_en(bist_en), .busy(busy),
        .done(done), .pass(pass), .signature(signature),
        .pattern_cnt(pattern_cnt), .state(state_s)
    );

    bist_ctrl #(.CHAIN_LEN(200), .N_PATTERNS(1)) dut_long (
        .CK(clk), .reset_n(rst_n), .start(start_l), .abort(abort_l), .so(so_l),
        .si(si_l), .scan_en(scan_en_l), .bist_en(bist_en_l), .busy(busy_l),
        .done(done_l), .pass(pass_l), .signature(signature_l),
        .pattern_cnt(pattern_cnt_l), .state(state_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] step7(input logic [6:0] q);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 7; i++)
            if (POLY[i]) fb = fb ^ q[i];
        return {q[5:0], fb};
    endfunction

    function automatic logic exp_scan(input logic run, input int k);
        if (!run) return 1'b0;
        if (k < RUN_SC) return (k % (L + 1)) != L;
        return k < RUN_SC + L;
    endfunction

    // Reference model: position in the run is tracked as a plain cycle count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0;
            m_k <= 0; m_pcnt <= 0; m_tpg <= 7'h01; m_misr <= 7'h00;
        end else if (abort) begin
            m_run <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0;
        end else if (!m_run) begin
            if (start) begin
                m_run <= 1'b1; m_k <= 0; m_pcnt <= 0; m_tpg <= 7'h01;
                m_misr <= 7'h00; m_done <= 1'b0; m_pass <= 1'b0;
            end
        end else begin
            m_k <= m_k + 1;
            if (m_k < RUN_SC) begin
                if ((m_k % (L + 1)) < L) begin
                    m_tpg <= step7(m_tpg);
                    if (m_k >= L + 1) m_misr <= step7(m_misr) ^ so;
                end else begin
                    m_pcnt <= m_pcnt + 1;
                end
            end else if (m_k < RUN_SC + L) begin
                m_misr <= step7(m_misr) ^ so;
            end else begin
                m_pass <= (m_misr == 7'h00);
                m_done <= 1'b1;
                m_run  <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("si", 32'(si), 32'(m_tpg));
            check("scan_en", 32'(scan_en), 32'(exp_scan(m_run, m_k)));
            check("busy", 32'(busy), 32'(m_run));
            check("bist_en", 32'(bist_en), 32'(m_run));
            check("done", 32'(done), 32'(m_done));
            check("pass", 32'(pass), 32'(m_pass));
            check("signature", 32'(signature), 32'(m_misr));
            check("pattern_cnt", 32'(pattern_cnt), 32'(m_pcnt));
        end
    end

    function automatic logic [6:0] so_val(input int mode, input int i);
        case (mode)
            1:       return (i == 10) ? 7'h01 : 7'h00;
            2:       return (i < 4) ? 7'bxxxxxxx : 7'((i * 13 + 5) & 127);
            default: return 7'h00;
        endcase
    endfunction

    task automatic run_small(input int mode, input int abort_at, input int start_at,
                             output logic [15:0] se_bits, output int done_at,
                             output logic [3:0] ab_snap);
        se_bits = '0;
        done_at = -1;
        ab_snap = '0;
        @(negedge clk);
        #1 start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i < 16) se_bits[i] = scan_en;
            if (done && done_at < 0) done_at = i;
            if (i == abort_at + 1) ab_snap = {busy, bist_en, scan_en, done};
            #1;
            start = (i == start_at);
            abort = (i == abort_at);
            so    = so_val(mode, i);
        end
        start = 1'b0;
        abort = 1'b0;
        so    = 7'h00;
    endtask

    logic [15:0] se_bits;
    int          done_at;
    logic [3:0]  ab_snap;
    logic [6:0]  ref_tpg;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; so = 7'h00;
        start_l = 1'b0; abort_l = 1'b0; so_l = 7'h00;
        #12;
        check("rst_si", 32'(si), 32'h01);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_scan_en", 32'(scan_en), 32'h0);
        check("rst_sig", 32'(signature), 32'h0);
        check("rst_state", 32'(state_s), 32'(ST_IDLE));
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // so held at 0, with a stray start while busy
        run_small(0, -1, 6, se_bits, done_at, ab_snap);
        check("scan_en_seq", 32'(se_bits), 32'h3DEF);
        check("done_latency", 32'(done_at), 32'd15);
        check("pcnt_end", 32'(pattern_cnt), 32'd2);
        check("sig_zero", 32'(signature), 32'h00);
        check("pass_zero", 32'(pass), 32'h1);

        // single so[0] pulse in the first unload cycle: 01 -> 02 -> 04 -> 08
        run_small(1, -1, -1, se_bits, done_at, ab_snap);
        check("sig_pulse", 32'(signature), 32'h08);
        check("pass_pulse", 32'(pass), 32'h0);
        check("done_latency2", 32'(done_at), 32'd15);

        // unknown scan-outs during the first load must not reach the MISR
        run_small(2, -1, -1, se_bits, done_at, ab_snap);
        check("sig_known", 32'($isunknown(signature)), 32'h0);
        check("done_latency3", 32'(done_at), 32'd15);

        // abort in the first capture cycle
        run_small(1, 4, -1, se_bits, done_at, ab_snap);
        check("abort_snap", 32'(ab_snap), 32'h0);
        check("abort_no_done", 32'(done_at), 32'hFFFF_FFFF);
        check("abort_state", 32'(state_s), 32'(ST_IDLE));

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        #1 start = 1'b1; abort = 1'b1;
        @(negedge clk);
        check("abort_start_busy", 32'(busy), 32'h0);
        check("abort_start_state", 32'(state_s), 32'(ST_IDLE));
        #1 start = 1'b0; abort = 1'b0;

        run_small(1, -1, -1, se_bits, done_at, ab_snap);
        check("rerun_sig", 32'(signature), 32'h08);
        check("rerun_done", 32'(done_at), 32'd15);

        // asynchronous reset in the middle of SHIFT, checked before any edge
        @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_scan_en", 32'(scan_en), 32'h0);
        check("arst_bist_en", 32'(bist_en), 32'h0);
        check("arst_si", 32'(si), 32'h01);
        check("arst_pcnt", 32'(pattern_cnt), 32'h0);
        check("arst_state", 32'(state_s), 32'(ST_IDLE));
        @(negedge clk);
        #1 rst_n = 1'b1;

        // TPG sequence over a full period on the long-chain instance
        @(negedge clk);
        #1 start_l = 1'b1;
        ref_tpg = 7'h01;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            check("tpg_seq", 32'(si_l), 32'(ref_tpg));
            if (i < 7) check("tpg_lit", 32'(si_l), 32'(lit[i]));
            if (i == 127) check("tpg_wrap", 32'(si_l), 32'h01);
            ref_tpg = step7(ref_tpg);
            #1 start_l = 1'b0;
        end
        #1 abort_l = 1'b1;
        @(negedge clk);
        check("long_abort", 32'(busy_l), 32'h0);
        #1 abort_l = 1'b0;

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
